// File: rtl/aes_pkg.sv
// Shared AES types, constants and helper functions for the key-schedule and round logic.
package aes_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 60;
  localparam int unsigned IDX_W     = 6;

  typedef enum logic [1:0] {
    KS128 = 2'b00,
    KS192 = 2'b01,
    KS256 = 2'b10
  } key_size_e;

  // Map the raw two-bit key_size port onto the key-size enum (2'b1x selects 256-bit).
  function automatic key_size_e ks_decode(input logic [1:0] raw);
    key_size_e ks;
    if (raw[1]) begin
      ks = KS256;
    end else if (raw[0]) begin
      ks = KS192;
    end else begin
      ks = KS128;
    end
    return ks;
  endfunction

  // Number of 32-bit words in the cipher key.
  function automatic logic [IDX_W-1:0] nk_of(input key_size_e ks);
    logic [IDX_W-1:0] n;
    case (ks)
      KS192:   n = 6'd6;
      KS256:   n = 6'd8;
      default: n = 6'd4;
    endcase
    return n;
  endfunction

  // Number of cipher rounds.
  function automatic logic [3:0] nr_of(input key_size_e ks);
    logic [3:0] n;
    case (ks)
      KS192:   n = 4'd12;
      KS256:   n = 4'd14;
      default: n = 4'd10;
    endcase
    return n;
  endfunction

  // Total schedule words, 4 * (Nr + 1).
  function automatic logic [IDX_W-1:0] total_words_of(input key_size_e ks);
    logic [IDX_W-1:0] n;
    case (ks)
      KS192:   n = 6'd52;
      KS256:   n = 6'd60;
      default: n = 6'd44;
    endcase
    return n;
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on one 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [2047:0]     sbox,
  output logic [WORD_W-1:0] result
);

  // Each byte indexes the flat S-box bus; entry b lives at sbox[2047-8*b -: 8].
  always_comb begin
    result = '0;
    for (int b = 0; b < 4; b++) begin
      result[31-8*b -: 8] = sbox[11'd2047 - {word[31-8*b -: 8], 3'b000} -: 8];
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key expansion: one schedule word per clock, results published as round keys.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic                eph1,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          key_size,
  input  logic [255:0]        key,
  input  logic [2047:0]       SBOX,
  output logic                busy,
  output logic                ready,
  output logic [3:0]          num_rounds,
  output logic [15:1][127:0]  key_words
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EXPAND = 2'b01,
    DONE   = 2'b10
  } state_e;

  state_e            state;
  key_size_e         ks;
  logic [WORD_W-1:0] w [NUM_WORDS];
  logic [IDX_W-1:0]  idx;
  logic [2:0]        phase;
  logic [7:0]        rcon;

  logic [IDX_W-1:0]  nk;
  logic [IDX_W-1:0]  tw;
  logic [WORD_W-1:0] prev;
  logic [WORD_W-1:0] back;
  logic [WORD_W-1:0] sub_in;
  logic [WORD_W-1:0] sub_out;
  logic [WORD_W-1:0] temp;
  logic              last_phase;
  key_size_e         start_ks;
  logic [IDX_W-1:0]  start_nk;

  // Operand fetch for the word being generated this cycle.
  always_comb begin
    nk         = nk_of(ks);
    tw         = total_words_of(ks);
    prev       = w[idx - 6'd1];
    back       = w[idx - nk];
    last_phase = ({3'b000, phase} == (nk - 6'd1));
    sub_in     = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    start_ks   = ks_decode(key_size);
    start_nk   = nk_of(start_ks);
  end

  aes_sub_word u_sub_word (
    .word   (sub_in),
    .sbox   (SBOX),
    .result (sub_out)
  );

  // Select the mixing term: rotated+substituted+rcon, plain substitution (256-bit mid-key), or pass-through.
  always_comb begin
    temp = prev;
    if (phase == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h000000};
    end else if ((ks == KS256) && (phase == 3'd4)) begin
      temp = sub_out;
    end
  end

  // Control FSM and schedule word storage.
  always_ff @(posedge eph1) begin
    if (reset) begin
      state      <= IDLE;
      ks         <= KS128;
      busy       <= 1'b0;
      ready      <= 1'b0;
      num_rounds <= 4'd0;
      idx        <= '0;
      phase      <= '0;
      rcon       <= '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        w[k] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ks <= start_ks;
            for (int k = 0; k < 8; k++) begin
              w[k] <= (IDX_W'(k) < start_nk) ? key[255-32*k -: 32] : '0;
            end
            for (int k = 8; k < NUM_WORDS; k++) begin
              w[k] <= '0;
            end
            idx        <= start_nk;
            phase      <= 3'd0;
            rcon       <= 8'h01;
            ready      <= 1'b0;
            busy       <= 1'b1;
            num_rounds <= nr_of(start_ks);
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          w[idx] <= back ^ temp;
          idx    <= idx + 6'd1;
          phase  <= last_phase ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) begin
            rcon <= xtime(rcon);
          end
          if (idx == (tw - 6'd1)) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Live view of the word array in round-key layout; index 15 holds the round-0 key.
  always_comb begin
    key_words = '0;
    for (int r = 1; r <= 15; r++) begin
      for (int c = 0; c < 4; c++) begin
        key_words[r][127-32*c -: 32] = w[(15-r)*4 + c];
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: scoreboard of expected schedules plus FIPS-197 vectors.
module tb_aes_key_expand;

  logic               eph1;
  logic               reset;
  logic               start;
  logic [1:0]         key_size;
  logic [255:0]       key;
  logic [2047:0]      sbox;
  logic               busy;
  logic               ready;
  logic [3:0]         num_rounds;
  logic [15:1][127:0] key_words;

  typedef struct {
    string              tag;
    logic [15:1][127:0] kw;
    logic [3:0]         nr;
    int                 lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] tb_sb [256];
  int         n_total = 0;
  int         n_bad   = 0;

  localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand dut (
    .eph1       (eph1),
    .reset      (reset),
    .start      (start),
    .key_size   (key_size),
    .key        (key),
    .SBOX       (sbox),
    .busy       (busy),
    .ready      (ready),
    .num_rounds (num_rounds),
    .key_words  (key_words)
  );

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  // Forward S-box entry from GF(2^8) inverse followed by the affine transform.
  function automatic logic [7:0] sbox_entry(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00) begin
      for (int v = 1; v < 256; v++) begin
        if (gmul(b, 8'(v)) == 8'h01) inv = 8'(v);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {tb_sb[x[31:24]], tb_sb[x[23:16]], tb_sb[x[15:8]], tb_sb[x[7:0]]};
  endfunction

  // Reference key schedule in the textbook i mod Nk form.
  function automatic exp_t model(input logic [255:0] k, input logic [1:0] ks);
    exp_t        e;
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int          nk;
    int          t;
    nk = ks[1] ? 8 : (ks[0] ? 6 : 4);
    t  = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < t; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    e.kw = '0;
    for (int i = 0; i < 60; i++) e.kw[15 - i/4][127-32*(i%4) -: 32] = w[i];
    e.nr  = 4'(nk + 6);
    e.lat = t - nk;
    e.tag = "";
    return e;
  endfunction

  // Issue one expansion, push its expected result, then wait for ready and score it.
  task automatic run(input string tag, input logic [255:0] k, input logic [1:0] ks,
                     input bit scramble, input bit pulse_mid);
    exp_t e;
    int   n;
    @(negedge eph1);
    key      = k;
    key_size = ks;
    start    = 1'b1;
    e        = model(k, ks);
    e.tag    = tag;
    sb_q.push_back(e);
    @(negedge eph1);
    start = 1'b0;
    if (scramble) begin
      key      = ~k;
      key_size = ks ^ 2'b01;
    end
    check($sformatf("%s_ready_low", tag), 128'(ready), 128'(0));
    check($sformatf("%s_busy", tag), 128'(busy), 128'(1));
    n = 0;
    while (!ready && n < 100) begin
      if (pulse_mid && n == 10) begin
        start    = 1'b1;
        key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_size = 2'b10;
      end
      if (n == 11) start = 1'b0;
      @(negedge eph1);
      n++;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("%s_latency", e.tag), 128'(n), 128'(e.lat));
    check($sformatf("%s_num_rounds", e.tag), 128'(num_rounds), 128'(e.nr));
    check($sformatf("%s_busy_done", e.tag), 128'(busy), 128'(0));
    for (int r = 15; r >= 1; r--) begin
      check($sformatf("%s_rk%0d", e.tag, 15 - r), key_words[r], e.kw[r]);
    end
  endtask

  initial begin
    bit saw_ready;
    for (int b = 0; b < 256; b++) tb_sb[b] = sbox_entry(8'(b));
    for (int b = 0; b < 256; b++) sbox[2047-8*b -: 8] = tb_sb[b];

    reset    = 1'b1;
    start    = 1'b1;
    key      = KEY_A1;
    key_size = 2'b00;
    repeat (3) @(negedge eph1);
    start = 1'b0;
    check("rst_ready", 128'(ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_nr", 128'(num_rounds), 128'(0));
    @(negedge eph1);
    reset = 1'b0;
    @(negedge eph1);
    for (int r = 1; r <= 15; r++) check($sformatf("rst_kw%0d", r), key_words[r], 128'h0);
    check("idle_ready", 128'(ready), 128'(0));

    // A.1 with start pulses during expansion
    run("a1", KEY_A1, 2'b00, 1'b0, 1'b1);
    check("a1_kw15", key_words[15], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("a1_kw5", key_words[5], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int r = 1; r <= 4; r++) check($sformatf("a1_kw%0d_zero", r), key_words[r], 128'h0);

    // A.2 as a restart from DONE
    run("a2", KEY_A2, 2'b01, 1'b0, 1'b0);
    check("a2_kw3", key_words[3], 128'he98ba06f448c773c8ecc720401002202);

    // A.3 with inputs changed right after start
    run("a3", KEY_A3, 2'b10, 1'b1, 1'b0);
    check("a3_kw1", key_words[1], 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset at edge 20 of an A.3 expansion
    @(negedge eph1);
    key      = KEY_A3;
    key_size = 2'b10;
    start    = 1'b1;
    @(negedge eph1);
    start = 1'b0;
    repeat (19) @(negedge eph1);
    reset = 1'b1;
    @(negedge eph1);
    reset = 1'b0;
    check("abort_ready", 128'(ready), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_nr", 128'(num_rounds), 128'(0));
    for (int r = 1; r <= 15; r++) check($sformatf("abort_kw%0d", r), key_words[r], 128'h0);
    saw_ready = 1'b0;
    repeat (70) begin
      @(negedge eph1);
      if (ready) saw_ready = 1'b1;
    end
    check("abort_no_ready", 128'(saw_ready), 128'(0));

    // Recovery, input-hold on a 128-bit key, and a random key using the 2'b11 encoding
    run("a1_hold", KEY_A1, 2'b00, 1'b1, 1'b0);
    check("a1_hold_kw5", key_words[5], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run("rnd256", {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
        2'b11, 1'b0, 1'b0);
    run("a2_again", KEY_A2, 2'b01, 1'b1, 1'b1);

    check("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES key-expansion engine. It is the producer of the `key_words` / `ready` interface that `aes_build` consumes.
- Takes a 128/192/256-bit cipher key and the shared S-box bus, generates one 32-bit schedule word per clock, and publishes all round keys in `aes_build`'s `[15:1]` layout.
- Raises a sticky `ready` when the schedule is complete.
- Sits between the key-load logic and `aes_build`.

Parameters:
- NONE_FIXED, n/a, the block has no parameters; widths are set by the AES standard.

Ports:
- eph1  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to expand `key` / `key_size`.
- key_size  in  2  2'b00 = 128-bit key, 2'b01 = 192-bit key, 2'b1x = 256-bit key.
- key  in  256  cipher key, left-aligned. 128-bit uses `key[255:128]`; 192-bit uses `key[255:64]`.
- SBOX  in  2048  forward S-box; entry b at `SBOX[2047-8*b -: 8]`.
- busy  out  1  expansion in progress.
- ready  out  1  schedule complete and valid; sticky.
- num_rounds  out  4  10/12/14 for the latched key size.
- key_words  out  15x128  packed `[15:1][127:0]`; index 15 = round-0 key.

Behaviour:
- Reset (sync, active-high; cleared on the eph1 edge where `reset` = 1):
  - state = IDLE; `busy` = 0, `ready` = 0, `num_rounds` = 0.
  - All schedule words = 0, so `key_words` = 0.
  - `start` is ignored while `reset` = 1.
  - Reset mid-expansion aborts immediately; no partial `ready`.
- Constants: Nk = 4/6/8; Nr = 10/12/14; total words T = 44/52/60.
- Storage: 60 x 32-bit word array. Word i maps to `key_words[15 - i/4][127-32*(i%4) -: 32]`.
  - Word 0 = `key[255:224]`.
  - Indices beyond T stay 0; for 128-bit keys, `key_words[4:1]` = 0.
- States: IDLE, EXPAND, DONE.
  - IDLE/DONE + `start`:
    - Latch key size; load words 0..Nk-1 from `key`; clear words Nk..59.
    - Set i = Nk, phase counter j = 0, rcon = 8'h01.
    - `ready` <= 0, `busy` <= 1, `num_rounds` <= Nr; go to EXPAND.
  - EXPAND: each edge writes w[i] = w[i-Nk] ^ temp, where temp is built from w[i-1]:
    - j==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon <= xtime(rcon) (0x80 -> 0x1b).
    - Nk==8 and j==4: temp = SubWord(w[i-1]).
    - otherwise temp = w[i-1].
    - Then i <= i+1 and j <= (j==Nk-1) ? 0 : j+1.
    - RotWord rotates left by one byte. SubWord applies the S-box per byte.
  - On the edge writing i = T-1: `ready` <= 1, `busy` <= 0, go to DONE.
- Latency: `ready` rises on the edge 40 / 46 / 52 edges after the edge sampling `start` (T - Nk).
- `start` while EXPAND is ignored.
- `start` while DONE restarts: `ready` falls on the sampling edge and the old schedule is overwritten.
- `key_words` are a live view of the array. Contents are undefined to consumers while `ready` = 0.
- `key` and `key_size` are only sampled on the accepted `start` edge; later changes have no effect.

Decomposition:
- Shared package `aes_pkg`:
  - key-size enum (KS128 / KS192 / KS256).
  - functions nk_of(ks), nr_of(ks), total_words_of(ks).
  - xtime function.
  - localparam WORD_W = 32.
- Sub-module `aes_sub_word`: combinational; 32-bit word + SBOX bus -> 4 parallel S-box lookups. It is reusable by `aes_build`.

Test Plan:
- FIPS-197 A.1, 128-bit key:
  - Stimulus: `key[255:128]` = 2b7e151628aed2a6abf7158809cf4f3c, `start`.
  - Required: `ready` exactly 40 edges later; `key_words[15]` = that key; `key_words[5]` = d014f9a8c9ee2589e13f0cc8b6630ca6; `key_words[4:1]` = 0; `num_rounds` = 10.
- FIPS-197 A.2, 192-bit key:
  - Stimulus: `key[255:64]` = 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Required: `ready` after 46 edges; `key_words[3]` = e98ba06f448c773c8ecc720401002202; `num_rounds` = 12.
- FIPS-197 A.3, 256-bit key:
  - Stimulus: key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, `key_size` = 2'b10.
  - Required: `ready` after 52 edges; `key_words[1]` = fe4890d1e6188d0b046df344706c631e; `num_rounds` = 14.
- Reset mid-operation:
  - Stimulus: start A.3, assert `reset` at edge 20 for one cycle.
  - Required: next cycle `ready` = 0, `busy` = 0, `key_words` = 0; no `ready` until a new `start`.
- Start handling:
  - Stimulus: `start` pulses during EXPAND.
  - Required: ignored, and the A.1 result is unchanged.
  - Stimulus: `start` of A.2 while DONE.
  - Required: `ready` drops on that edge, then A.2 result 46 edges later with `key_words[4:1]` recomputed.
- Input-hold check:
  - Stimulus: change `key` / `key_size` one cycle after `start`.
  - Required: results match the values latched at `start`.
